// File: rtl/aes_inv_if.sv
// Request/response bundle for the inverse AES round engine.
// The master drives the request; the slave returns status and result.
interface aes_inv_if;
    logic         valid;
    logic [127:0] state_in;
    logic [127:0] key;
    logic         ready;
    logic [1:0]   count;
    logic         done;
    logic [127:0] data_out;

    modport master (
        output valid, state_in, key,
        input  ready, count, done, data_out
    );

    modport slave (
        input  valid, state_in, key,
        output ready, count, done, data_out
    );
endinterface

// File: rtl/aes_inv.sv
// Multi-cycle inverse AES round: InvMixColumns, then InvShiftRows, then AddRoundKey.
// Each step is one FSM state. The operands are captured on acceptance.
module aes_inv (
    input  logic     clk,
    input  logic     rst,
    aes_inv_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        INV_MIX_COLUMNS,
        INV_SHIFT_ROW,
        ADD_ROUND_KEY
    } state_t;

    state_t       state;
    logic [127:0] work;
    logic [127:0] key_reg;
    logic [127:0] data_out;
    logic [1:0]   count;
    logic         done;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Each column is multiplied by the circulant {0e,0b,0d,09}. The products are built from one xtime chain.
    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            r[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        return r;
    endfunction

    // Row r is rotated right by r columns. Row 0 is not moved.
    function automatic logic [127:0] inv_shift(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-32*c-8*w -: 8] = s[127-32*((c-w+4)%4)-8*w -: 8];
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            work     <= '0;
            key_reg  <= '0;
            data_out <= '0;
            count    <= 2'd0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.valid) begin
                        work    <= bus.state_in;
                        key_reg <= bus.key;
                        state   <= INV_MIX_COLUMNS;
                    end
                end
                INV_MIX_COLUMNS: begin
                    work  <= inv_mix(work);
                    count <= 2'd1;
                    state <= INV_SHIFT_ROW;
                end
                INV_SHIFT_ROW: begin
                    work  <= inv_shift(work);
                    count <= 2'd2;
                    state <= ADD_ROUND_KEY;
                end
                ADD_ROUND_KEY: begin
                    data_out <= work ^ key_reg;
                    count    <= 2'd3;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.count    = count;
    assign bus.done     = done;
    assign bus.data_out = data_out;

endmodule

// File: tb/tb_aes_inv.sv
// Directed and randomized bench for aes_inv.
// The expected results come from a byte-matrix model that does GF(2^8) arithmetic.
module tb_aes_inv;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    aes_inv_if bus ();

    aes_inv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running required=finished");
        $fatal(1);
    end

    // Shift-and-add multiplication in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] aa;
        logic [7:0] p;
        aa = {1'b0, a};
        p  = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa[7:0];
            aa = aa << 1;
            if (aa[8]) aa = aa ^ 9'h11B;
        end
        return p;
    endfunction

    function automatic logic [127:0] model_inv(input logic [127:0] s, input logic [127:0] k);
        logic [7:0]   a [4][4];
        logic [7:0]   b [4][4];
        logic [7:0]   co [4];
        logic [127:0] r;
        co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                a[w][c] = s[127-32*c-8*w -: 8];
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) begin
                b[w][c] = 8'h00;
                for (int j = 0; j < 4; j++)
                    b[w][c] = b[w][c] ^ gmul(co[(j-w+4)%4], a[j][c]);
            end
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-32*c-8*w -: 8] = b[w][(c-w+4)%4];
        return r ^ k;
    endfunction

    // Encryption-direction round body: ShiftRows(MixColumns input) of X^K.
    function automatic logic [127:0] model_fwd(input logic [127:0] x, input logic [127:0] k);
        logic [7:0]   a [4][4];
        logic [7:0]   b [4][4];
        logic [7:0]   co [4];
        logic [127:0] t;
        logic [127:0] r;
        co = '{8'h02, 8'h03, 8'h01, 8'h01};
        t  = x ^ k;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                a[w][c] = t[127-32*((c+w)%4)-8*w -: 8];
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) begin
                b[w][c] = 8'h00;
                for (int j = 0; j < 4; j++)
                    b[w][c] = b[w][c] ^ gmul(co[(j-w+4)%4], a[j][c]);
                r[127-32*c-8*w -: 8] = b[w][c];
            end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [127:0] st, input logic [127:0] k, input bit full,
                          input logic [127:0] exp);
        int w;
        w = 0;
        while (bus.ready !== 1'b1 && w < 10) begin
            tick();
            w++;
        end
        chk("ready_before_op", {127'd0, bus.ready}, 128'd1);
        bus.valid    = 1'b1;
        bus.state_in = st;
        bus.key      = k;
        tick();
        bus.valid    = 1'b0;
        bus.state_in = rnd128();
        bus.key      = rnd128();
        if (full) begin
            chk("ready_busy", {127'd0, bus.ready}, 128'd0);
            chk("done_after_accept", {127'd0, bus.done}, 128'd0);
        end
        tick();
        if (full) chk("count_imc", {126'd0, bus.count}, 128'd1);
        tick();
        if (full) begin
            chk("count_isr", {126'd0, bus.count}, 128'd2);
            chk("done_isr", {127'd0, bus.done}, 128'd0);
        end
        tick();
        chk("data_out", bus.data_out, exp);
        chk("done_pulse", {127'd0, bus.done}, 128'd1);
        if (full) begin
            chk("count_ark", {126'd0, bus.count}, 128'd3);
            chk("ready_at_done", {127'd0, bus.ready}, 128'd1);
        end
        tick();
        if (full) begin
            chk("done_cleared", {127'd0, bus.done}, 128'd0);
            chk("data_out_held", bus.data_out, exp);
            chk("count_held", {126'd0, bus.count}, 128'd3);
        end
    endtask

    logic [127:0] st_a [16];
    logic [127:0] k_a  [16];
    logic [127:0] x;
    logic [127:0] kk;
    int           ndone;
    int           m;

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        rst          = 1'b1;
        bus.valid    = 1'b0;
        bus.state_in = '0;
        bus.key      = '0;
        #2 rst = 1'b0;
        tick();
        tick();
        chk("rst_data_out", bus.data_out, 128'd0);
        chk("rst_count", {126'd0, bus.count}, 128'd0);
        chk("rst_done", {127'd0, bus.done}, 128'd0);
        chk("rst_ready", {127'd0, bus.ready}, 128'd1);
        rst = 1'b1;
        tick();

        run_op(128'h8e4da1bc_00000000_00000000_00000000, 128'd0, 1'b1,
               128'hdb000000_00130000_00005300_00000045);
        run_op({4{32'h01010101}}, {4{32'hffffffff}}, 1'b1, {4{32'hfefefefe}});
        chk("model_known", model_inv({4{32'h01010101}}, {4{32'hffffffff}}), {4{32'hfefefefe}});

        for (int i = 0; i < 32; i++) begin
            x  = rnd128();
            kk = rnd128();
            run_op(model_fwd(x, kk), kk, (i < 4), x);
        end

        // valid is held high for 12 edges. Acceptances are expected at edges 1, 5 and 9.
        ndone = 0;
        for (int i = 1; i <= 12; i++) begin
            st_a[i]      = rnd128();
            k_a[i]       = rnd128();
            bus.valid    = 1'b1;
            bus.state_in = st_a[i];
            bus.key      = k_a[i];
            tick();
            m = (i - 1) % 4;
            if (i >= 2)
                chk("b2b_count", {126'd0, bus.count}, (m == 0) ? 128'd3 : 128'(m));
            chk("b2b_done", {127'd0, bus.done}, (m == 3) ? 128'd1 : 128'd0);
            chk("b2b_ready", {127'd0, bus.ready}, (m == 3) ? 128'd1 : 128'd0);
            if (m == 3)
                chk("b2b_data", bus.data_out, model_inv(st_a[i-3], k_a[i-3]));
            ndone += int'(bus.done);
        end
        bus.valid = 1'b0;
        tick();
        chk("b2b_idle_done", {127'd0, bus.done}, 128'd0);
        chk("b2b_done_total", 128'(ndone), 128'd3);

        // The reset is applied while the FSM is in INV_SHIFT_ROW.
        x  = rnd128();
        kk = rnd128();
        bus.valid    = 1'b1;
        bus.state_in = x;
        bus.key      = kk;
        tick();
        bus.valid = 1'b0;
        tick();
        chk("pre_abort_count", {126'd0, bus.count}, 128'd1);
        rst = 1'b0;
        #1;
        chk("abort_data_out", bus.data_out, 128'd0);
        chk("abort_count", {126'd0, bus.count}, 128'd0);
        chk("abort_done", {127'd0, bus.done}, 128'd0);
        chk("abort_ready", {127'd0, bus.ready}, 128'd1);
        tick();
        tick();
        chk("abort_no_done", {127'd0, bus.done}, 128'd0);
        rst = 1'b1;
        tick();
        tick();
        chk("post_abort_done", {127'd0, bus.done}, 128'd0);
        chk("post_abort_data", bus.data_out, 128'd0);
        x  = rnd128();
        kk = rnd128();
        run_op(x, kk, 1'b1, model_inv(x, kk));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_inv.md
AES_INV -- requirements
Module: aes_inv

Interface
REQ-001 The block SHALL have one clock domain; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-004 valid  input  1  request to start one inverse round.
REQ-005 state_in  input  128  round output to invert; column-major: column c = [127-32c -: 32], row r byte = [127-32c-8r -: 8].
REQ-006 key  input  128  round key, same byte layout.
REQ-007 ready  output  1  high only in IDLE; request accepted on a clk edge with valid && ready.
REQ-008 count  output  2  current step indicator.
REQ-009 done  output  1  one-cycle pulse when data_out is updated.
REQ-010 data_out  output  128  recovered plaintext state.

Function
REQ-011 The block SHALL compute data_out = InvShiftRows(InvMixColumns(state_in)) ^ key, using the state_in and key values captured at acceptance.
REQ-012 The FSM SHALL have states IDLE, INV_MIX_COLUMNS, INV_SHIFT_ROW and ADD_ROUND_KEY, with transitions IDLE -(valid)-> INV_MIX_COLUMNS -> INV_SHIFT_ROW -> ADD_ROUND_KEY -> IDLE, and no other transitions.
REQ-013 On acceptance the block SHALL load state_in into an internal 128-bit work register and load key into an internal key register.
REQ-014 In INV_MIX_COLUMNS the block SHALL replace each column (a0..a3) with: b0=0e·a0^0b·a1^0d·a2^09·a3, b1=09·a0^0e·a1^0b·a2^0d·a3, b2=0d·a0^09·a1^0e·a2^0b·a3, b3=0b·a0^0d·a1^09·a2^0e·a3; set count=1.
REQ-015 GF(2^8) multiplication SHALL be built from xtime, where xtime(x) = (x<<1)[7:0] ^ (x[7] ? 8'h1B : 0); all results SHALL be 8 bits.
REQ-016 In INV_SHIFT_ROW the block SHALL right-rotate row r by r columns (new[r][c] = old[r][(c-r) mod 4]) with row 0 unchanged; set count=2.
REQ-017 In ADD_ROUND_KEY the block SHALL register data_out <= work ^ key register, set count=3 and set done=1 for exactly that registered cycle.
REQ-018 In IDLE, done SHALL be 0, while count and data_out SHALL hold their last values.
REQ-019 Latency SHALL be fixed: for acceptance at edge N, data_out and done are valid after edge N+3, and ready returns high after edge N+3.
REQ-020 valid SHALL be ignored while ready=0: no restart, and the captured key/state are not disturbed.
REQ-021 Back-to-back operation SHALL be supported: valid held high gives one acceptance every 4 cycles, and the done cycle coincides with ready=1.
REQ-022 Changing state_in or key after acceptance SHALL NOT affect the result.

Reset
REQ-023 While rst=0 the block SHALL force the FSM to IDLE and drive count=0, done=0 and data_out=0, with the internal work and key registers also 0.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first valid after rst deasserts SHALL start a fresh operation.

Verification
REQ-025 state_in=8e4da1bc_00000000_00000000_00000000, key=0 -> data_out=db000000_00130000_00005300_00000045, count=3, done pulses once 3 cycles after acceptance.
REQ-026 state_in=01010101_01010101_01010101_01010101, key=ffffffff_ffffffff_ffffffff_ffffffff -> data_out=fefefefe_fefefefe_fefefefe_fefefefe.
REQ-027 Round trip: state_in = MixColumns(ShiftRows(X^K)) computed by the encryption round for 32 random X/K pairs -> data_out == X for every pair.
REQ-028 valid held high for 12 cycles -> exactly 3 acceptances and 3 done pulses, spaced 4 cycles apart; count sequence 1,2,3 per operation.
REQ-029 rst pulled low in INV_SHIFT_ROW -> data_out=0, count=0, done=0 immediately; a new request after release completes with the correct value.
REQ-030 state_in and key changed one cycle after acceptance -> result matches the captured values.
